mouse_cursor_sequencer: RTL and testbench
=========================================

// Module: mouse_cursor_sequencer
// PURPOSE
//  Sequences the 160x120 VGA pixel writer from PS/2 mouse traffic.
//  - Assembles standard 3-byte mouse packets and tracks a clamped cursor position.
//  - Per packet: erases the old square cursor, then draws the new one, through one plot port.
//  - Sits between PS2_Controller (received_data/en) and vga_adapter (x, y, colour, plot).
// PARAMETERS
//  X_MAX           159     last valid screen column
//  Y_MAX           119     last valid screen row
//  CURSOR_SIZE     2       cursor square side in pixels, legal 1..4
//  SPEED_SHIFT     1       arithmetic right shift applied to mouse deltas
//  TIMEOUT_CYCLES  100000  max gap between packet bytes (2 ms @ 50 MHz)
//  BG_COLOUR       3'b000  colour used for erase
//  X_INIT / Y_INIT 80 / 60 cursor origin after reset
// PORTS
//  clock       in   1  system clock, 50 MHz
//  resetN      in   1  reset, asynchronous, active-low
//  rx_data     in   8  PS/2 byte
//  rx_valid    in   1  1-cycle strobe, rx_data valid
//  colour_in   in   3  cursor colour, sampled in CALC
//  x           out  8  VGA plot column
//  y           out  7  VGA plot row
//  colour      out  3  VGA plot colour
//  plot        out  1  pixel write strobe
//  busy        out  1  high in CALC/ERASE/DRAW/INIT_DRAW
//  buttons     out  3  {mid,right,left} from last accepted packet
//  sync_error  out  1  1-cycle pulse on discarded byte or timeout
// BEHAVIOUR
//  Reset: all outputs 0; pos = (X_INIT,Y_INIT); state INIT_DRAW (draws cursor once, no erase).
//  FSM: INIT_DRAW->IDLE; IDLE->B1->B2->CALC->ERASE->DRAW->IDLE.
//  - IDLE: rx_valid with rx_data[3]==1 -> latch byte0, go B1; rx_data[3]==0 -> pulse sync_error, stay.
//  - B1/B2: latch dx / dy on rx_valid; gap counter > TIMEOUT_CYCLES -> sync_error, IDLE.
//  - CALC (1 cycle): compute new pos; sample colour_in; update buttons = byte0[2:0].
//  - ERASE/DRAW: CURSOR_SIZE^2 cycles each, plot=1 every cycle.
//    Row-major order: col offset fastest; x=px+i, y=py+j. ERASE uses old pos + BG_COLOUR.
//    DRAW uses new pos + sampled colour.
//  - rx_valid in CALC/ERASE/DRAW: byte dropped, sync_error pulses; next IDLE byte resyncs via bit3.
//  Arithmetic:
//  - dx = {byte0[4],byte1}, dy = {byte0[5],byte2}: 9-bit signed.
//  - Overflow bit byte0[6]/[7] set -> that axis delta forced to 0.
//  - Deltas >>> SPEED_SHIFT (arithmetic, rounds toward -inf).
//  - nx = x + dx, ny = y - dy (screen y down), computed in 11-bit signed.
//  - Clamp to [0, X_MAX-CURSOR_SIZE+1] and [0, Y_MAX-CURSOR_SIZE+1]; never wraps.
//  Timing:
//  - Outputs registered. First ERASE plot is 2 cycles after the byte2 rx_valid cycle.
//  - Last DRAW plot followed by IDLE (plot=0) next cycle.
//  - x/y/colour hold last value when plot=0.
//  Reset mid-operation: immediate abort; plot=0. Half-drawn pixels stay; INIT_DRAW redraws at origin.
// CONFIGURATION
//  CURSOR_PAINT_EN defined: when latched byte0[0] (left) is 1, ERASE skipped.
//  - CALC->DRAW directly, old cursor left on screen as paint trail.
//  CURSOR_PAINT_EN undefined: ERASE always performed; left button only reported on buttons.
// TESTING
//  1 Reset, default params -> INIT_DRAW plots (80,60),(81,60),(80,61),(81,61); then busy=0.
//  2 Packet 08,0A,04 -> erase 4 px at (80,60) colour 0; draw at (85,58); buttons=0.
//  3 Packet 18,F6,00 (dx=-10) from x=2 -> x clamps 0. Packet 08,FF,00 at x=150 -> x clamps 158.
//  4 Byte 00 in IDLE -> sync_error pulse, no plot. Bytes 08,05 then 200000-cycle gap -> sync_error, IDLE.
//  5 Packet 48,FF,02 (X overflow) -> dx=0; only y changes by -1.
//  6 CURSOR_PAINT_EN on, packet 09,04,00 -> no ERASE plots, 4 DRAW plots, buttons=001.
//    Assert resetN low mid-DRAW -> plot=0 immediately.

Source files
------------

// File: rtl/mouse_cursor_sequencer.sv
// PS/2 mouse packet assembler driving erase/redraw of a square cursor via one plot port.
// Optional CURSOR_PAINT_EN: held left button skips the erase, leaving a paint trail.
module mouse_cursor_sequencer #(
  parameter int         X_MAX          = 159,
  parameter int         Y_MAX          = 119,
  parameter int         CURSOR_SIZE    = 2,
  parameter int         SPEED_SHIFT    = 1,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter int         X_INIT         = 80,
  parameter int         Y_INIT         = 60
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [2:0] buttons,
  output logic       sync_error
);

  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [1:0] LAST = 2'(CURSOR_SIZE - 1);
  localparam logic [7:0] XC   = 8'(X_MAX - CURSOR_SIZE + 1);
  localparam logic [6:0] YC   = 7'(Y_MAX - CURSOR_SIZE + 1);

  typedef enum logic [2:0] {
    INIT_DRAW, IDLE, B1, B2, CALC, ERASE, DRAW
  } state_t;

  state_t        state;
  logic [7:0]    px, qx, b1, b2;
  logic [6:0]    py, qy;
  logic          ov_x, ov_y, sx, sy;
  logic [2:0]    btn, col;
  logic [1:0]    i, j;
  logic [TW-1:0] gap;

  logic signed [8:0]  dx9, dy9, dxs, dys;
  logic signed [10:0] nx, ny;
  logic [7:0]         cx;
  logic [6:0]         cy;
  logic [1:0]         ni, nj;
  logic               last, skip_erase;

  always_comb begin
    dx9 = ov_x ? 9'sd0 : {sx, b1};
    dy9 = ov_y ? 9'sd0 : {sy, b2};
    dxs = dx9 >>> SPEED_SHIFT;
    dys = dy9 >>> SPEED_SHIFT;
    // screen y grows downward, mouse y grows upward
    nx = $signed({3'b000, px}) + $signed({{2{dxs[8]}}, dxs});
    ny = $signed({4'b0000, py}) - $signed({{2{dys[8]}}, dys});
    cx = nx[10] ? 8'd0 : (nx > {3'b000, XC}) ? XC : nx[7:0];
    cy = ny[10] ? 7'd0 : (ny > {4'b0000, YC}) ? YC : ny[6:0];
    last = (i == LAST) && (j == LAST);
    ni = (i == LAST) ? 2'd0 : i + 2'd1;
    nj = (i == LAST) ? j + 2'd1 : j;
`ifdef CURSOR_PAINT_EN
    skip_erase = btn[0];
`else
    skip_erase = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= INIT_DRAW;
      px         <= 8'(X_INIT);
      py         <= 7'(Y_INIT);
      qx         <= '0;
      qy         <= '0;
      b1         <= '0;
      b2         <= '0;
      ov_x       <= 1'b0;
      ov_y       <= 1'b0;
      sx         <= 1'b0;
      sy         <= 1'b0;
      btn        <= '0;
      col        <= '0;
      i          <= '0;
      j          <= '0;
      gap        <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      buttons    <= '0;
      sync_error <= 1'b0;
    end else begin
      sync_error <= 1'b0;
      unique case (state)
        INIT_DRAW: begin
          // pixel (i,j) is emitted at this edge, no erase
          plot   <= 1'b1;
          busy   <= 1'b1;
          x      <= px + {6'b0, i};
          y      <= py + {5'b0, j};
          colour <= colour_in;
          sync_error <= rx_valid;
          if (last) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
          end else begin
            i <= ni;
            j <= nj;
          end
        end
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          if (rx_valid) begin
            if (rx_data[3]) begin
              ov_y  <= rx_data[7];
              ov_x  <= rx_data[6];
              sy    <= rx_data[5];
              sx    <= rx_data[4];
              btn   <= rx_data[2:0];
              gap   <= '0;
              state <= B1;
            end else begin
              sync_error <= 1'b1;
            end
          end
        end
        B1: begin
          if (rx_valid) begin
            b1    <= rx_data;
            gap   <= '0;
            state <= B2;
          end else if (gap > TMO) begin
            sync_error <= 1'b1;
            state      <= IDLE;
          end else begin
            gap <= gap + TW'(1);
          end
        end
        B2: begin
          if (rx_valid) begin
            b2    <= rx_data;
            busy  <= 1'b1;
            state <= CALC;
          end else if (gap > TMO) begin
            sync_error <= 1'b1;
            state      <= IDLE;
          end else begin
            gap <= gap + TW'(1);
          end
        end
        CALC: begin
          sync_error <= rx_valid;
          col     <= colour_in;
          buttons <= btn;
          qx      <= cx;
          qy      <= cy;
          i       <= '0;
          j       <= '0;
          plot    <= 1'b1;
          if (skip_erase) begin
            state  <= DRAW;
            px     <= cx;
            py     <= cy;
            x      <= cx;
            y      <= cy;
            colour <= colour_in;
          end else begin
            state  <= ERASE;
            x      <= px;
            y      <= py;
            colour <= BG_COLOUR;
          end
        end
        ERASE: begin
          sync_error <= rx_valid;
          if (last) begin
            state  <= DRAW;
            px     <= qx;
            py     <= qy;
            x      <= qx;
            y      <= qy;
            colour <= col;
            i      <= '0;
            j      <= '0;
          end else begin
            x <= px + {6'b0, ni};
            y <= py + {5'b0, nj};
            i <= ni;
            j <= nj;
          end
        end
        DRAW: begin
          sync_error <= rx_valid;
          if (last) begin
            state <= IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
            i     <= '0;
            j     <= '0;
          end else begin
            x <= px + {6'b0, ni};
            y <= py + {5'b0, nj};
            i <= ni;
            j <= nj;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_cursor_sequencer.sv
// Directed bench for mouse_cursor_sequencer: packets, clamping, sync, paint, reset.
// Honours CURSOR_PAINT_EN the same way the design does.
module tb_mouse_cursor_sequencer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [2:0] colour_in = 3'b110;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, sync_error;
  logic [2:0] buttons;

  int tests = 0;
  int fails = 0;
  int serr = 0;
  logic [17:0] q[$];

  mouse_cursor_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .resetN(resetN), .rx_data(rx_data),
    .rx_valid(rx_valid), .colour_in(colour_in), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .buttons(buttons),
    .sync_error(sync_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (plot) q.push_back({x, y, colour});
    if (sync_error) serr++;
  end

  function automatic logic [17:0] pix(input int bx, input int by,
                                      input int k, input logic [2:0] c);
    return {8'(bx + k % 2), 7'(by + k / 2), c};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic packet(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
    send(a);
    send(b);
    send(c);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    tests++;
    if ({plot, busy, x, y, colour, buttons, sync_error} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got plot=%b busy=%b x=%0d y=%0d want all 0",
               plot, busy, x, y);
    end
    q.delete();
    resetN = 1'b1;
    repeat (8) @(negedge clock);
    tests++;
    if (q.size() != 4) begin
      fails++;
      $display("FAIL init_count got %0d want 4", q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (q[k] !== pix(80, 60, k, 3'b110)) begin
          fails++;
          $display("FAIL init_pix%0d got %h want %h", k, q[k], pix(80, 60, k, 3'b110));
        end
      end
    end
    tests++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      fails++;
      $display("FAIL init_done got busy=%b plot=%b want 0 0", busy, plot);
    end
  endtask

  task automatic test_packet;
    q.delete();
    colour_in = 3'b011;
    packet(8'h08, 8'h0A, 8'h04);
    tests++;
    if (plot !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL calc_cycle got plot=%b busy=%b want 0 1", plot, busy);
    end
    @(negedge clock);
    colour_in = 3'b110;
    tests++;
    if ({plot, x, y, colour} !== {1'b1, 8'd80, 7'd60, 3'd0}) begin
      fails++;
      $display("FAIL first_erase got plot=%b x=%0d y=%0d c=%0d want 1 80 60 0",
               plot, x, y, colour);
    end
    repeat (12) @(negedge clock);
    tests++;
    if (q.size() != 8) begin
      fails++;
      $display("FAIL pkt_count got %0d want 8", q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        logic [17:0] e;
        e = (k < 4) ? pix(80, 60, k, 3'b000) : pix(85, 58, k - 4, 3'b011);
        tests++;
        if (q[k] !== e) begin
          fails++;
          $display("FAIL pkt_pix%0d got %h want %h", k, q[k], e);
        end
      end
    end
    tests++;
    if (buttons !== 3'b000 || plot !== 1'b0) begin
      fails++;
      $display("FAIL pkt_end got buttons=%b plot=%b want 000 0", buttons, plot);
    end
  endtask

  task automatic test_clamp;
    packet(8'h18, 8'h5A, 8'h00);
    repeat (12) @(negedge clock);
    q.delete();
    packet(8'h18, 8'hF6, 8'h00);
    repeat (12) @(negedge clock);
    tests++;
    if (q.size() != 8 || q[0] !== pix(2, 58, 0, 3'b000) ||
        q[4] !== pix(0, 58, 0, 3'b110)) begin
      fails++;
      $display("FAIL clamp_low got n=%0d e0=%h d0=%h want 8 %h %h", q.size(),
               q[0], q[4], pix(2, 58, 0, 3'b000), pix(0, 58, 0, 3'b110));
    end
    packet(8'h08, 8'hFF, 8'h00);
    repeat (12) @(negedge clock);
    packet(8'h08, 8'h2E, 8'h00);
    repeat (12) @(negedge clock);
    q.delete();
    packet(8'h08, 8'hFF, 8'h00);
    repeat (12) @(negedge clock);
    tests++;
    if (q.size() != 8 || q[0] !== pix(150, 58, 0, 3'b000) ||
        q[4] !== pix(158, 58, 0, 3'b110) || q[7] !== pix(158, 58, 3, 3'b110)) begin
      fails++;
      $display("FAIL clamp_high got n=%0d e0=%h d0=%h d3=%h want x 150->158",
               q.size(), q[0], q[4], q[7]);
    end
  endtask

  task automatic test_overflow;
    q.delete();
    packet(8'h48, 8'hFF, 8'h02);
    repeat (12) @(negedge clock);
    tests++;
    if (q.size() != 8 || q[0] !== pix(158, 58, 0, 3'b000) ||
        q[4] !== pix(158, 57, 0, 3'b110)) begin
      fails++;
      $display("FAIL overflow got n=%0d e0=%h d0=%h want %h %h", q.size(),
               q[0], q[4], pix(158, 58, 0, 3'b000), pix(158, 57, 0, 3'b110));
    end
  endtask

  task automatic test_sync;
    q.delete();
    serr = 0;
    send(8'h00);
    repeat (3) @(negedge clock);
    tests++;
    if (serr != 1 || q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bad_header got serr=%0d plots=%0d busy=%b want 1 0 0",
               serr, q.size(), busy);
    end
    send(8'h08);
    send(8'h05);
    repeat (200) @(negedge clock);
    tests++;
    if (serr != 2) begin
      fails++;
      $display("FAIL timeout got serr=%0d want 2", serr);
    end
    packet(8'h08, 8'h00, 8'h00);
    repeat (12) @(negedge clock);
    tests++;
    if (q.size() != 8 || q[4] !== pix(158, 57, 0, 3'b110)) begin
      fails++;
      $display("FAIL resync got n=%0d d0=%h want 8 %h", q.size(), q[4],
               pix(158, 57, 0, 3'b110));
    end
  endtask

  task automatic test_busy_drop;
    q.delete();
    serr = 0;
    packet(8'h18, 8'hFD, 8'h00);
    send(8'h08);
    repeat (12) @(negedge clock);
    tests++;
    if (serr != 1 || q.size() != 8 || q[4] !== pix(156, 57, 0, 3'b110)) begin
      fails++;
      $display("FAIL busy_drop got serr=%0d n=%0d d0=%h want 1 8 %h", serr,
               q.size(), q[4], pix(156, 57, 0, 3'b110));
    end
  endtask

  task automatic test_buttons;
    int n;
    q.delete();
    packet(8'h0A, 8'h00, 8'h00);
    repeat (12) @(negedge clock);
    tests++;
    if (buttons !== 3'b010 || q.size() != 8) begin
      fails++;
      $display("FAIL buttons got btn=%b n=%0d want 010 8", buttons, q.size());
    end
    q.delete();
    packet(8'h09, 8'h04, 8'h00);
    repeat (12) @(negedge clock);
`ifdef CURSOR_PAINT_EN
    n = 4;
`else
    n = 8;
`endif
    tests++;
    if (buttons !== 3'b001 || q.size() != n ||
        q[n-4] !== pix(158, 57, 0, 3'b110) || q[0] === pix(156, 57, 0, 3'b000) && n == 4) begin
      fails++;
      $display("FAIL paint got btn=%b n=%0d d0=%h want 001 %0d %h", buttons,
               q.size(), q[n-4], n, pix(158, 57, 0, 3'b110));
    end
  endtask

  task automatic test_reset_mid_draw;
    packet(8'h08, 8'h00, 8'h00);
    repeat (6) @(negedge clock);
    tests++;
    if (plot !== 1'b1 || colour !== 3'b110) begin
      fails++;
      $display("FAIL mid_draw_pre got plot=%b c=%0d want 1 6", plot, colour);
    end
    resetN = 1'b0;
    #1;
    tests++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_draw_abort got plot=%b busy=%b want 0 0", plot, busy);
    end
    @(negedge clock);
    q.delete();
    resetN = 1'b1;
    repeat (8) @(negedge clock);
    tests++;
    if (q.size() != 4 || q[0] !== pix(80, 60, 0, 3'b110) ||
        q[3] !== pix(80, 60, 3, 3'b110)) begin
      fails++;
      $display("FAIL redraw got n=%0d p0=%h want 4 %h", q.size(), q[0],
               pix(80, 60, 0, 3'b110));
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_clamp();
    test_overflow();
    test_sync();
    test_busy_drop();
    test_buttons();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
